// File: rtl/bitblade_slice_mul_seq_pkg.sv
// Shared types and constants for the sliced 2b multiplier sequencer.
package bitblade_pkg;

  localparam int SLICE_W     = 2;
  localparam int CELL_PROD_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bitblade_slice_mul_seq_if.sv
// Operand-in / product-out valid-ready bundle for bitblade_slice_mul_seq.
interface bitblade_slice_mul_seq_if #(
  parameter int N_SLICE = 4,
  parameter int ACC_W   = 4 * N_SLICE + 1
);

  logic                   in_valid;
  logic                   in_ready;
  logic [2*N_SLICE-1:0]   in_a;
  logic [2*N_SLICE-1:0]   in_b;
  logic                   in_sign_i;
  logic                   in_sign_w;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_prod;

  modport master (
    output in_valid, in_a, in_b, in_sign_i, in_sign_w, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sign_i, in_sign_w, out_ready,
    output in_ready, out_valid, out_prod
  );

endinterface

// File: rtl/bitblade_slice_mul_seq_cell.sv
// 2b x 2b reconfigurable multiplier cell; each operand is signed when its sign input is set.
module MUL_reconfigurable_3_3 (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       SignI,
  input  logic       SignW,
  output logic [5:0] MUL
);

  logic signed [2:0] a_ext;
  logic signed [2:0] b_ext;
  logic signed [5:0] prod;

  assign a_ext = {SignI & A[1], A};
  assign b_ext = {SignW & B[1], B};
  assign prod  = a_ext * b_ext;
  assign MUL   = prod;

endmodule

// File: rtl/bitblade_slice_mul_seq.sv
// Sequential wide multiplier: walks all 2b slice pairs through one cell and shift-adds the partial products.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | one slice pair per cycle, accumulating shifted cell products
// DONE  | out_valid high, product held until out_ready
module bitblade_slice_mul_seq
  import bitblade_pkg::*;
#(
  parameter int N_SLICE = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  bitblade_slice_mul_seq_if.slave bus
);

  localparam int ACC_W = 4 * N_SLICE + 1;
  localparam int OP_W  = SLICE_W * N_SLICE;
  localparam int IDX_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICE - 1);

  state_t                  state;
  logic [IDX_W-1:0]        i_idx;
  logic [IDX_W-1:0]        j_idx;
  logic [OP_W-1:0]         a_q;
  logic [OP_W-1:0]         b_q;
  logic                    sign_i_q;
  logic                    sign_w_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] prod_ext;
  logic [SLICE_W-1:0]      a_slice;
  logic [SLICE_W-1:0]      b_slice;
  logic                    cell_sign_i;
  logic                    cell_sign_w;
  logic [CELL_PROD_W-1:0]  cell_prod;
  logic                    last_pair;

  // Only the top slice of a signed operand carries the sign weight.
  always_comb begin
    a_slice     = a_q[SLICE_W*int'(i_idx) +: SLICE_W];
    b_slice     = b_q[SLICE_W*int'(j_idx) +: SLICE_W];
    cell_sign_i = sign_i_q & (i_idx == LAST_IDX);
    cell_sign_w = sign_w_q & (j_idx == LAST_IDX);
    prod_ext    = {{(ACC_W-CELL_PROD_W){cell_prod[CELL_PROD_W-1]}}, cell_prod};
    acc_next    = acc + (prod_ext << (SLICE_W * (int'(i_idx) + int'(j_idx))));
    last_pair   = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);
  end

  MUL_reconfigurable_3_3 u_cell (
    .A     (a_slice),
    .B     (b_slice),
    .SignI (cell_sign_i),
    .SignW (cell_sign_w),
    .MUL   (cell_prod)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_prod  <= '0;
      i_idx         <= '0;
      j_idx         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sign_i_q      <= 1'b0;
      sign_w_q      <= 1'b0;
      acc           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q          <= bus.in_a;
            b_q          <= bus.in_b;
            sign_i_q     <= bus.in_sign_i;
            sign_w_q     <= bus.in_sign_w;
            acc          <= '0;
            i_idx        <= '0;
            j_idx        <= '0;
            bus.in_ready <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (j_idx == LAST_IDX) begin
            j_idx <= '0;
            i_idx <= i_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
          if (last_pair) begin
            i_idx         <= '0;
            bus.out_prod  <= acc_next;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitblade_slice_mul_seq.sv
// Directed table plus scoreboarded random sweep for bitblade_slice_mul_seq.
module tb_bitblade_slice_mul_seq;

  localparam int N_VEC    = 11;
  localparam int N_SWEEP  = 2000;
  localparam int LAT      = 16;
  localparam int SWEEP_CY = 50000;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       si;
    logic       sw;
    int         exp;
    int         hold;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_acc;
  int   n_res;
  int   n_drv;
  int   exp_q[$];
  vec_t vecs[N_VEC];

  bitblade_slice_mul_seq_if #(.N_SLICE(4)) bus ();

  bitblade_slice_mul_seq #(.N_SLICE(4)) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int prod_now();
    return int'($signed(bus.out_prod));
  endfunction

  function automatic int ref_prod(input logic [7:0] a, input logic [7:0] b,
                                  input logic si, input logic sw);
    int ai;
    int bi;
    ai = si ? int'($signed(a)) : int'(a);
    bi = sw ? int'($signed(b)) : int'(b);
    return ai * bi;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int  k;
    int  lat;
    bit  ready_seen;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready_idle"}, int'(bus.in_ready), 1);
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.in_sign_i = v.si;
    bus.in_sign_w = v.sw;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat        = 0;
    ready_seen = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_prod"}, prod_now(), v.exp);
    check({tag, "_ready_calc"}, int'(ready_seen), 0);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      check({tag, "_hold_prod"}, prod_now(), v.exp);
      check({tag, "_hold_ready"}, int'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, int'(bus.out_valid), 0);
    check({tag, "_ready_back"}, int'(bus.in_ready), 1);
    check({tag, "_prod_kept"}, prod_now(), v.exp);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'd255,  8'd255,  1'b0, 1'b0,  65025, 0};
    vecs[1]  = '{8'h80,   8'h80,   1'b1, 1'b1,  16384, 0};
    vecs[2]  = '{8'hFF,   8'd255,  1'b1, 1'b0,   -255, 0};
    vecs[3]  = '{8'd3,    8'd5,    1'b0, 1'b0,     15, 0};
    vecs[4]  = '{8'h12,   8'h34,   1'b0, 1'b0,    936, 5};
    vecs[5]  = '{8'h7F,   8'h80,   1'b1, 1'b1, -16256, 0};
    vecs[6]  = '{8'h80,   8'hFF,   1'b0, 1'b1,   -128, 0};
    vecs[7]  = '{8'hFF,   8'hFF,   1'b1, 1'b1,      1, 0};
    vecs[8]  = '{8'h80,   8'h03,   1'b1, 1'b0,   -384, 0};
    vecs[9]  = '{8'h55,   8'hAA,   1'b1, 1'b1,  -7310, 0};
    vecs[10] = '{8'h00,   8'd200,  1'b1, 1'b0,      0, 0};

    clk           = 1'b0;
    rst_n         = 1'b0;
    n_checks      = 0;
    n_errors      = 0;
    n_acc         = 0;
    n_res         = 0;
    n_drv         = 0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sign_i = 1'b0;
    bus.in_sign_w = 1'b0;
    bus.out_ready = 1'b0;

    #23;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_prod", prod_now(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < N_VEC; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v));
    end

    // Abort in the middle of CALC; out_prod still holds the last vector's value beforehand.
    begin
      vec_t v15;
      bit   spur;
      @(negedge clk);
      bus.in_a      = 8'd255;
      bus.in_b      = 8'd255;
      bus.in_sign_i = 1'b0;
      bus.in_sign_w = 1'b0;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", int'(bus.in_ready), 1);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_out_prod", prod_now(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      spur = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) spur = 1'b1;
      end
      check("midrst_no_result", int'(spur), 0);
      v15 = '{8'd3, 8'd5, 1'b0, 1'b0, 15, 0};
      run_vec(v15, "after_rst");
    end

    // Back-to-back sweep across all sign modes, scoreboarded at the interface.
    @(negedge clk);
    bus.out_ready = 1'b1;
    fork
      begin
        for (int c = 0; c < SWEEP_CY && n_drv < N_SWEEP; c++) begin
          @(negedge clk);
          if (bus.in_ready) begin
            bus.in_a      = 8'($urandom_range(0, 255));
            bus.in_b      = 8'($urandom_range(0, 255));
            bus.in_sign_i = n_drv[0];
            bus.in_sign_w = n_drv[1];
            bus.in_valid  = 1'b1;
            @(posedge clk);
            n_drv++;
          end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < SWEEP_CY && n_res < N_SWEEP; c++) begin
          @(posedge clk);
          if (bus.out_valid && bus.out_ready) begin
            n_res++;
            check("sweep_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("sweep_prod", prod_now(), exp_q.pop_front());
          end
          if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_prod(bus.in_a, bus.in_b, bus.in_sign_i, bus.in_sign_w));
            n_acc++;
          end
        end
      end
    join
    check("sweep_accepts", n_acc, N_SWEEP);
    check("sweep_results", n_res, N_SWEEP);
    check("sweep_leftover", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
